// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared widths, lane positions, state/port enums and lane merge helper
package sram_arb_pkg;

    localparam int ADDR_W  = 20;
    localparam int MEM_W   = 48;
    localparam int CPU_W   = 32;
    localparam int VID_W   = 16;
    localparam int CPU_LSB = 0;
    localparam int VID_LSB = MEM_W - VID_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAITW,
        ST_WR,
        ST_ACK
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_VID = 1'b1
    } port_t;

    // Replace the granted port's lane of the read-back word, keep the other lane.
    // The video data sits in the low VID_W bits of din.
    function automatic logic [MEM_W-1:0] merge_lane(
        input logic [MEM_W-1:0] hold,
        input port_t            port,
        input logic [CPU_W-1:0] din
    );
        logic [MEM_W-1:0] word;
        word = hold;
        if (port == PORT_CPU) begin
            word[CPU_LSB +: CPU_W] = din;
        end else begin
            word[VID_LSB +: VID_W] = din[VID_W-1:0];
        end
        return word;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - request/acknowledge bus of one SRAM requester port
// Signals: stb (request, held until ack), we (1=write), addr (word address),
//          din (write lane data), dout (read lane data, valid with ack), ack (one-cycle completion)
// master: requester side; slave: arbiter side.
interface sram_port_arbiter_if #(
    parameter int DW = sram_arb_pkg::CPU_W
) ();
    import sram_arb_pkg::*;

    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     din;
    logic [DW-1:0]     dout;
    logic              ack;

    modport master (
        output stb, we, addr, din,
        input  dout, ack
    );

    modport slave (
        input  stb, we, addr, din,
        output dout, ack
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter between CPU and video ports
// Inputs:  req_cpu, req_vid (pending requests), last (port granted most recently)
// Outputs: grant_valid (some request pending), grant (winning port),
//          next_last (pointer value to store when the grant is taken)
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic  req_cpu,
    input  logic  req_vid,
    input  port_t last,
    output logic  grant_valid,
    output port_t grant,
    output port_t next_last
);

    always_comb begin
        grant_valid = req_cpu | req_vid;
        grant       = PORT_CPU;
        if (req_cpu && req_vid) begin
            // Tie: the port that did not win last time goes first.
            grant = (last == PORT_CPU) ? PORT_VID : PORT_CPU;
        end else if (req_vid) begin
            grant = PORT_VID;
        end
        next_last = grant_valid ? grant : last;
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one 48-bit async SRAM between CPU, video-write and VGA scan
// Ports: clk_50mhz, rst_n (async active-low), init_busy (blocks new grants),
//        cpu (slave, 32-bit lane [31:0]), vid (slave, 16-bit lane [47:32]),
//        scan_addr / scan_data / scan_valid (fixed scan slot every other cycle),
//        mem_addr / mem_wdata / mem_rdata / mem_we / mem_oe (to the SRAM pad driver).
module sram_port_arbiter
    import sram_arb_pkg::*;
(
    input  logic                clk_50mhz,
    input  logic                rst_n,
    input  logic                init_busy,
    sram_port_arbiter_if.slave  cpu,
    sram_port_arbiter_if.slave  vid,
    input  logic [ADDR_W-1:0]   scan_addr,
    output logic [VID_W-1:0]    scan_data,
    output logic                scan_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [MEM_W-1:0]    mem_wdata,
    input  logic [MEM_W-1:0]    mem_rdata,
    output logic                mem_we,
    output logic                mem_oe
);

    // phase=1 is the scan slot, phase=0 the access slot.
    logic              phase;
    state_t            state;
    port_t             gnt_port;
    port_t             rr_last;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [CPU_W-1:0]  lat_din;
    logic [MEM_W-1:0]  hold;
    logic [CPU_W-1:0]  cpu_dout_q;
    logic [VID_W-1:0]  vid_dout_q;
    logic              cpu_ack_q;
    logic              vid_ack_q;

    logic  grant_valid;
    port_t grant;
    port_t next_last;

    rr_arb2 u_rr_arb2 (
        .req_cpu     (cpu.stb),
        .req_vid     (vid.stb),
        .last        (rr_last),
        .grant_valid (grant_valid),
        .grant       (grant),
        .next_last   (next_last)
    );

    assign cpu.dout = cpu_dout_q;
    assign cpu.ack  = cpu_ack_q;
    assign vid.dout = vid_dout_q;
    assign vid.ack  = vid_ack_q;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= 1'b0;
            state      <= ST_IDLE;
            gnt_port   <= PORT_CPU;
            rr_last    <= PORT_VID;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_din    <= '0;
            hold       <= '0;
            cpu_dout_q <= '0;
            vid_dout_q <= '0;
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
            scan_data  <= '0;
            scan_valid <= 1'b0;
        end else begin
            phase      <= ~phase;
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
            // The scan slot is serviced regardless of state or init_busy.
            scan_valid <= phase;
            if (phase) begin
                scan_data <= mem_rdata[VID_LSB +: VID_W];
            end

            case (state)
                ST_IDLE: begin
                    if (phase && !init_busy && grant_valid) begin
                        gnt_port <= grant;
                        rr_last  <= next_last;
                        lat_addr <= (grant == PORT_CPU) ? cpu.addr : vid.addr;
                        lat_we   <= (grant == PORT_CPU) ? cpu.we   : vid.we;
                        lat_din  <= (grant == PORT_CPU) ? cpu.din
                                                        : {{(CPU_W-VID_W){1'b0}}, vid.din};
                        state    <= ST_RD;
                    end
                end
                ST_RD: begin
                    // Writes read first so the untouched lane is written back intact.
                    if (!phase) begin
                        hold  <= mem_rdata;
                        state <= lat_we ? ST_WAITW : ST_ACK;
                    end
                end
                ST_WAITW: begin
                    if (phase) begin
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (!phase) begin
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (phase) begin
                        if (gnt_port == PORT_CPU) begin
                            cpu_ack_q  <= 1'b1;
                            cpu_dout_q <= hold[CPU_LSB +: CPU_W];
                        end else begin
                            vid_ack_q  <= 1'b1;
                            vid_dout_q <= hold[VID_LSB +: VID_W];
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // SRAM controls decode straight from registered state so an async reset
    // removes mem_we in the same cycle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        if (phase) begin
            mem_addr = scan_addr;
            mem_oe   = 1'b1;
        end else if (state == ST_RD) begin
            mem_addr = lat_addr;
            mem_oe   = 1'b1;
        end else if (state == ST_WR) begin
            mem_addr  = lat_addr;
            mem_we    = 1'b1;
            mem_wdata = merge_lane(hold, gnt_port, lat_din);
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              init_busy;
    logic [ADDR_W-1:0] scan_addr;
    logic [VID_W-1:0]  scan_data;
    logic              scan_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;
    logic              mem_we;
    logic              mem_oe;

    sram_port_arbiter_if #(.DW(CPU_W)) cpu_if ();
    sram_port_arbiter_if #(.DW(VID_W)) vid_if ();

    sram_port_arbiter dut (
        .clk_50mhz  (clk),
        .rst_n      (rst_n),
        .init_busy  (init_busy),
        .cpu        (cpu_if),
        .vid        (vid_if),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .scan_valid (scan_valid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_oe     (mem_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model indexed by address bits [7:4]; preloaded during the first reset.
    logic [MEM_W-1:0] mem [0:15];
    logic             mem_loaded = 1'b0;
    assign mem_rdata = mem[mem_addr[7:4]];

    always @(posedge clk) begin
        if (!rst_n && !mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[1]     <= 48'h1234_89ABCDEF;
            mem[2]     <= 48'h1234_00000000;
            mem[3]     <= 48'h7777_00000000;
            mem[4]     <= 48'h0000_CAFEF00D;
            mem[5]     <= 48'h5A5A_00000000;
            mem[6]     <= 48'hAAAA_11111111;
            mem[7]     <= 48'hBBBB_22222222;
            mem_loaded <= 1'b1;
        end else if (rst_n && mem_we) begin
            mem[mem_addr[7:4]] <= mem_wdata;
        end
    end

    // Cycle index since reset release; even = access slot, odd = scan slot.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        port_t       port;
        logic [31:0] data;
        int          at;
    } ack_exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [MEM_W-1:0]  wdata;
        int                at;
    } wr_exp_t;

    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_ack(input port_t port, input logic [31:0] data);
        ack_exp_t e;
        if (ack_q.size() == 0) begin
            check("unexpected_ack_port", 64'(port), 64'hFF);
        end else begin
            e = ack_q.pop_front();
            check("ack_port", 64'(port), 64'(e.port));
            check("ack_dout", 64'(data), 64'(e.data));
            check("ack_cycle", 64'(cyc), 64'(e.at));
        end
    endtask

    task automatic mon_wr();
        wr_exp_t e;
        if (wr_q.size() == 0) begin
            check("unexpected_mem_we", 64'(mem_we), 64'h0);
        end else begin
            e = wr_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(e.addr));
            check("wr_data", 64'(mem_wdata), 64'(e.wdata));
            check("wr_cycle", 64'(cyc), 64'(e.at));
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("scan_valid", 64'(scan_valid), 64'((cyc >= 2) && (cyc % 2 == 0)));
            if (scan_valid) check("scan_data", 64'(scan_data), 64'h5A5A);
            if (cpu_if.ack) mon_ack(PORT_CPU, cpu_if.dout);
            if (vid_if.ack) mon_ack(PORT_VID, {16'h0, vid_if.dout});
            if (mem_we)     mon_wr();
        end
    end

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_cpu_ack"},   64'(cpu_if.ack),  0);
        check({tag, "_cpu_dout"},  64'(cpu_if.dout), 0);
        check({tag, "_vid_ack"},   64'(vid_if.ack),  0);
        check({tag, "_vid_dout"},  64'(vid_if.dout), 0);
        check({tag, "_scan_data"}, 64'(scan_data),   0);
        check({tag, "_scan_valid"},64'(scan_valid),  0);
        check({tag, "_mem_addr"},  64'(mem_addr),    0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata),   0);
        check({tag, "_mem_we"},    64'(mem_we),      0);
        check({tag, "_mem_oe"},    64'(mem_oe),      0);
    endtask

    function automatic int next_scan(input int c);
        return (c % 2 == 1) ? c : c + 1;
    endfunction

    // Issue one request from idle at a falling edge and hold stb until its ack.
    task automatic req(input port_t port, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] din, input logic [31:0] exp_dout,
                       input logic [MEM_W-1:0] exp_wdata);
        int c, s, ack_at;
        c = cyc;
        s = next_scan(c);
        ack_at = s + (we ? 5 : 3);
        if (port == PORT_CPU) begin
            cpu_if.stb = 1'b1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.din = din;
        end else begin
            vid_if.stb = 1'b1; vid_if.we = we; vid_if.addr = addr; vid_if.din = din[15:0];
        end
        ack_q.push_back('{port, exp_dout, ack_at});
        if (we) wr_q.push_back('{addr, exp_wdata, s + 3});
        repeat (ack_at - c) @(negedge clk);
        if (port == PORT_CPU) cpu_if.stb = 1'b0;
        else                  vid_if.stb = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c, s;
        rst_n = 1'b0; init_busy = 1'b0; scan_addr = 20'h00050;
        cpu_if.stb = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.din = '0;
        vid_if.stb = 1'b0; vid_if.we = 1'b0; vid_if.addr = '0; vid_if.din = '0;

        repeat (3) @(negedge clk);
        check_quiet_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        req(PORT_CPU, 1'b0, 20'h00010, 32'h0, 32'h89ABCDEF, '0);
        req(PORT_CPU, 1'b1, 20'h00020, 32'hDEADBEEF, 32'h0, 48'h1234_DEADBEEF);
        req(PORT_VID, 1'b1, 20'hABC40, 32'hFFFF, 32'h0, 48'hFFFF_CAFEF00D);
        req(PORT_CPU, 1'b0, 20'hABC40, 32'h0, 32'hCAFEF00D, '0);
        req(PORT_VID, 1'b0, 20'h00020, 32'h0, 32'h1234, '0);

        // Both ports held: CPU, VID, CPU, VID.
        c = cyc; s = next_scan(c);
        cpu_if.stb = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 20'h00060;
        vid_if.stb = 1'b1; vid_if.we = 1'b0; vid_if.addr = 20'h00070;
        ack_q.push_back('{PORT_CPU, 32'h11111111, s + 3});
        ack_q.push_back('{PORT_VID, 32'h0000BBBB, s + 7});
        ack_q.push_back('{PORT_CPU, 32'h11111111, s + 11});
        ack_q.push_back('{PORT_VID, 32'h0000BBBB, s + 15});
        repeat (s + 11 - c) @(negedge clk);
        cpu_if.stb = 1'b0;
        repeat (4) @(negedge clk);
        vid_if.stb = 1'b0;
        repeat (2) @(negedge clk);

        // init_busy blocks the grant until it drops.
        init_busy = 1'b1;
        cpu_if.stb = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 20'h00010;
        repeat (8) @(negedge clk);
        init_busy = 1'b0;
        c = cyc; s = next_scan(c);
        ack_q.push_back('{PORT_CPU, 32'h89ABCDEF, s + 3});
        repeat (s + 3 - c) @(negedge clk);
        cpu_if.stb = 1'b0;
        repeat (2) @(negedge clk);

        // Reset asserted inside the WR cycle: write strobe drops, no ack.
        c = cyc; s = next_scan(c);
        cpu_if.stb = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 20'h00030; cpu_if.din = 32'h11112222;
        wr_q.push_back('{20'h00030, 48'h7777_11112222, s + 3});
        repeat (s + 3 - c) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_mem_we", 64'(mem_we), 0);
        check("rst_mid_wr_cpu_ack", 64'(cpu_if.ack), 0);
        cpu_if.stb = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet_outputs("rst2");
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_wr_mem_kept", 64'(mem[3]), 64'h7777_00000000);

        check("ack_q_drained", 64'(ack_q.size()), 0);
        check("wr_q_drained", 64'(wr_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
